// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC array sequencer: the 2-bit per-row
// instruction encodings, the dataflow mode constants, the sequencer FSM state
// type, and small decode helpers that map an FSM state to what it issues.
// -----------------------------------------------------------------------------
package mac_pkg;

    // Per-row instruction encodings (bit 1 = execute, bit 0 = load / OS flush)
    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;
    localparam logic [1:0] INST_OS   = 2'b11;

    // Dataflow select
    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GAP   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Instruction issued to row 0 while the FSM sits in a given state.
    function automatic logic [1:0] issue_of(input state_e st, input logic mode);
        logic [1:0] inst;
        case (st)
            ST_LOAD:  inst = INST_LOAD;
            ST_FLUSH: inst = INST_LOAD;
            ST_EXEC:  inst = (mode == MODE_OS) ? INST_OS : INST_EXEC;
            default:  inst = INST_IDLE;
        endcase
        return inst;
    endfunction

    // States in which the L0 FIFO is read (weights in LOAD, activations in EXEC).
    function automatic logic reads_l0(input state_e st);
        logic rd;
        case (st)
            ST_LOAD: rd = 1'b1;
            ST_EXEC: rd = 1'b1;
            default: rd = 1'b0;
        endcase
        return rd;
    endfunction

endpackage

// File: rtl/mac_array_seq_inst_skew.sv
// -----------------------------------------------------------------------------
// inst_skew
// STAGES-deep shift chain of 2-bit instructions. Stage r drives row r of the
// MAC array, so row r sees the row-0 instruction r cycles later.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high clear of every stage
//   inst_i  in   instruction entering stage 0
//   inst_o  out  all stages, row r in bits [2r+1:2r]
// -----------------------------------------------------------------------------
module inst_skew
    import mac_pkg::*;
#(
    parameter int unsigned STAGES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            inst_i,
    output logic [2*STAGES-1:0]   inst_o
);

    logic [2*STAGES-1:0] chain_q;

    // Shift the instruction one row further south every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q[1:0] <= inst_i;
            for (int r = 1; r < STAGES; r++) begin
                chain_q[2*r +: 2] <= chain_q[2*(r-1) +: 2];
            end
        end
    end

    assign inst_o = chain_q;

endmodule

// File: rtl/mac_array_seq.sv
// -----------------------------------------------------------------------------
// mac_array_seq
// Instruction sequencer for the stacked mac_row array. A start pulse walks
// LOAD -> GAP -> EXEC -> DRAIN (weight-stationary) or EXEC -> FLUSH -> DRAIN
// (output-stationary), then DONE. Row-0 instructions are skewed one cycle per
// row by inst_skew.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               command pulse, honoured only when idle
//   mode_in, num_vec    dataflow mode and execute-vector count, latched on start
//   inst_w              per-row instruction, row r in bits [2r+1:2r]
//   mode_select         latched mode for every mac_row
//   l0_rd               L0 read strobe (L0 data arrives one cycle later)
//   busy, done          run in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module mac_array_seq
    import mac_pkg::*;
#(
    parameter int unsigned row    = 8,
    parameter int unsigned col    = 8,
    parameter int unsigned cnt_bw = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode_in,
    input  logic [cnt_bw-1:0]   num_vec,
    output logic [2*row-1:0]    inst_w,
    output logic                mode_select,
    output logic                l0_rd,
    output logic                busy,
    output logic                done
);

    localparam logic [cnt_bw-1:0] CNT_ONE    = cnt_bw'(1);
    localparam logic [cnt_bw-1:0] LOAD_LAST  = cnt_bw'(col - 1);
    localparam logic [cnt_bw-1:0] FLUSH_LAST = cnt_bw'(row - 1);
    localparam logic [cnt_bw-1:0] DRAIN_LAST = cnt_bw'(row + col - 1);

    state_e              state_q;
    logic [cnt_bw-1:0]   cnt_q;
    logic [cnt_bw-1:0]   num_q;
    logic                mode_q;
    logic [1:0]          issue_q;
    logic                l0_rd_q;
    logic                busy_q;
    logic                done_q;

    // Sequencer FSM: phase counters plus outputs registered from the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            mode_q  <= MODE_WS;
            issue_q <= INST_IDLE;
            l0_rd_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Outputs follow the state one cycle later; row-0 inst_w lags
            // l0_rd by a further stage so it lines up with L0 read data.
            issue_q <= issue_of(state_q, mode_q);
            l0_rd_q <= reads_l0(state_q);
            busy_q  <= (state_q != ST_IDLE) && (state_q != ST_DONE);
            done_q  <= (state_q == ST_DONE);

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    // done_q marks the visible DONE cycle; a start there is dropped.
                    if (start && !done_q) begin
                        mode_q <= mode_in;
                        num_q  <= num_vec;
                        if (mode_in == MODE_WS) begin
                            state_q <= ST_LOAD;
                        end else if (num_vec == '0) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_EXEC;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == LOAD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    cnt_q <= '0;
                    if (num_q == '0) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // cnt_q tops out at num_q-1, so num_vec = all-ones never wraps.
                    if ((cnt_q + CNT_ONE) == num_q) begin
                        cnt_q   <= '0;
                        state_q <= (mode_q == MODE_OS) ? ST_FLUSH : ST_DRAIN;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    inst_skew #(
        .STAGES (row)
    ) u_inst_skew (
        .clk    (clk),
        .reset  (reset),
        .inst_i (issue_q),
        .inst_o (inst_w)
    );

    assign mode_select = mode_q;
    assign l0_rd       = l0_rd_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mac_array_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_array_seq
// Directed and randomized runs of the MAC array sequencer. Expected outputs
// come from a phase list built from the dataflow rules: one entry per issue
// cycle (instruction, L0 read), then shifted by the read latency and row skew.
// -----------------------------------------------------------------------------
module tb_mac_array_seq;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int CBW = 8;

    logic                clk;
    logic                reset;
    logic                start;
    logic                mode_in;
    logic [CBW-1:0]      num_vec;
    logic [2*ROW-1:0]    inst_w;
    logic                mode_select;
    logic                l0_rd;
    logic                busy;
    logic                done;

    int n_assert;
    int n_fail;

    typedef struct packed {
        logic [1:0] inst;
        logic       rd;
    } issue_t;

    issue_t seq[$];

    mac_array_seq #(
        .row    (ROW),
        .col    (COL),
        .cnt_bw (CBW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode_in     (mode_in),
        .num_vec     (num_vec),
        .inst_w      (inst_w),
        .mode_select (mode_select),
        .l0_rd       (l0_rd),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Issue-cycle list for one run, straight from the phase rules.
    task automatic build(input bit m, input int n);
        seq.delete();
        if (m == 1'b0) begin
            repeat (COL) seq.push_back('{inst: 2'b01, rd: 1'b1});
            seq.push_back('{inst: 2'b00, rd: 1'b0});
            repeat (n) seq.push_back('{inst: 2'b10, rd: 1'b1});
        end else if (n > 0) begin
            repeat (n) seq.push_back('{inst: 2'b11, rd: 1'b1});
            repeat (ROW) seq.push_back('{inst: 2'b01, rd: 1'b0});
        end
        repeat (ROW + COL) seq.push_back('{inst: 2'b00, rd: 1'b0});
    endtask

    // One accepted start. k counts cycles after the accepting edge t0.
    // rst_at >= 0: reset is sampled at edge t0+rst_at.
    // tog: scramble mode_in/num_vec after start. poke: extra start pulses
    // while busy and across the DONE cycles.
    task automatic run(input bit m, input int n, input int rst_at, input bit tog, input bit poke);
        int len;
        int last;
        int idx;
        logic [2*ROW-1:0] e_inst;
        logic e_rd, e_busy, e_done, e_mode;
        bit in_rst;
        build(m, n);
        len  = seq.size();
        last = (rst_at >= 0) ? rst_at + 2 : len + 4;
        @(negedge clk);
        start   = 1'b1;
        mode_in = m;
        num_vec = CBW'(n);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            in_rst = (rst_at >= 0) && (k >= rst_at);
            e_rd   = (k >= 1 && k <= len) ? seq[k-1].rd : 1'b0;
            e_busy = (k >= 1 && k <= len);
            e_done = (k == len + 1);
            e_mode = m;
            for (int r = 0; r < ROW; r++) begin
                idx = k - 2 - r;
                e_inst[2*r +: 2] = (idx >= 0 && idx < len) ? seq[idx].inst : 2'b00;
            end
            if (in_rst) begin
                e_inst = '0;
                e_rd   = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b0;
                e_mode = 1'b0;
            end
            check("inst_w", k, 64'(inst_w), 64'(e_inst));
            check("l0_rd", k, 64'(l0_rd), 64'(e_rd));
            check("busy", k, 64'(busy), 64'(e_busy));
            check("done", k, 64'(done), 64'(e_done));
            check("mode_select", k, 64'(mode_select), 64'(e_mode));
            // Drive inputs for the following edges.
            if (k == 0) start = 1'b0;
            if (rst_at >= 0 && k == rst_at - 1) reset = 1'b1;
            if (rst_at >= 0 && k == rst_at) reset = 1'b0;
            if (tog) begin
                mode_in = 1'($urandom);
                num_vec = CBW'($urandom);
            end
            if (poke) begin
                if (k == 5) start = 1'b1;
                if (k == 6) start = 1'b0;
                if (k == len) start = 1'b1;
                if (k == len + 2) start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        mode_in  = 1'b0;
        num_vec  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_inst_w", 0, 64'(inst_w), 64'd0);
        check("rst_l0_rd", 0, 64'(l0_rd), 64'd0);
        check("rst_busy", 0, 64'(busy), 64'd0);
        check("rst_done", 0, 64'(done), 64'd0);
        check("rst_mode", 0, 64'(mode_select), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 1, 64'(busy), 64'd0);

        run(1'b0, 4, 11, 1'b0, 1'b0);     // reset mid-EXEC
        run(1'b0, 4, -1, 1'b0, 1'b0);     // WS N=4, done at t0+30
        run(1'b1, 4, -1, 1'b0, 1'b0);     // OS N=4, done at t0+29
        run(1'b0, 0, -1, 1'b0, 1'b0);     // WS N=0, done at t0+26
        run(1'b0, 4, -1, 1'b0, 1'b1);     // start while busy / in DONE
        run(1'b1, 4, -1, 1'b1, 1'b0);     // mode_in toggled mid-run
        run(1'b0, 255, -1, 1'b0, 1'b0);   // counter full range
        for (int i = 0; i < 4; i++) begin
            run(1'($urandom_range(0, 1)), int'($urandom_range(1, 20)), -1, 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
